pid_channel_scheduler: RTL and testbench

- Time-shares one PI arithmetic datapath across NCH wheel channels of the chassis.
- On each control-period tick, it snapshots all targets and feedback, then computes each channel in turn: drive = process + (Kp*err >>> SHIFT) + (Ki*integral >>> SHIFT), saturated.
- Holds the per-channel integrator state and reports sequencing status and overruns.
- Sits between the encoder/speed-measurement front end and the PWM drive stage.

---
 rtl/pid_channel_scheduler.sv | 212 +++++++++++++++++++++
 tb/tb_pid_channel_scheduler.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/pid_channel_scheduler.sv
// pid_channel_scheduler
// Time-shares one PI datapath across NCH wheel channels. On each tick it
// snapshots every target and process word. It then runs each channel through
// ERR -> MULP -> MULI -> SUM, which takes four cycles per channel, and writes
// a saturated drive word. The integrator state for each channel is kept here,
// together with the sequencing status and a saturating count of dropped ticks.
//
// Optional build macro: PID_INT_CLAMP_EN
//   When it is defined, the updated integrator is limited to +/-INT_LIM before
//   it is used and before it is stored (anti-windup). When it is undefined,
//   the W+8 bit integrator wraps in two's complement.
module pid_channel_scheduler #(
    parameter int NCH     = 4,
    parameter int W       = 32,
    parameter int SHIFT   = 3,
    parameter int OUT_LIM = 20000,
    parameter int INT_LIM = 1000000
) (
    input  logic               clk,
    input  logic               nRst,
    input  logic               tick,
    input  logic [NCH*W-1:0]   target_flat,
    input  logic [NCH*W-1:0]   process_flat,
    input  logic [W-1:0]       kp,
    input  logic [W-1:0]       ki,
    input  logic [NCH-1:0]     clear_int,
    output logic [NCH*W-1:0]   drive_flat,
    output logic [NCH-1:0]     drive_valid,
    output logic               busy,
    output logic               done,
    output logic [7:0]         overrun_cnt
);

    // Working widths. The error needs one bit more than its operands. The
    // integrator has eight bits of headroom. The products are kept at full
    // width, and the sum gets two guard bits over the widest product.
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int EW  = W + 1;
    localparam int IW  = W + 8;
    localparam int PPW = W + EW;
    localparam int PIW = W + IW;
    localparam int SW  = PIW + 2;

    localparam logic signed [SW-1:0] OUT_HI = SW'(OUT_LIM);
    localparam logic signed [SW-1:0] OUT_LO = -OUT_HI;

    // An illegal configuration stops elaboration instead of producing a
    // silently broken datapath.
    if (NCH < 2 || NCH > 8 || W < 2 || SHIFT < 0 || OUT_LIM < 1 || INT_LIM < 1) begin : g_param_range
        $error("pid_channel_scheduler: parameter out of range");
    end

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ERR  = 3'd1,
        ST_MULP = 3'd2,
        ST_MULI = 3'd3,
        ST_SUM  = 3'd4
    } state_t;

    state_t                  state_r;
    logic [CW-1:0]           ch_r;
    logic [NCH*W-1:0]        shadow_tgt_r;
    logic [NCH*W-1:0]        shadow_proc_r;
    logic signed [IW-1:0]    int_r [NCH];
    logic signed [EW-1:0]    err_r;
    logic signed [IW-1:0]    int_new_r;
    logic signed [PPW-1:0]   prod_p_r;
    logic signed [PIW-1:0]   prod_i_r;
    logic [NCH*W-1:0]        drive_r;
    logic [NCH-1:0]          drive_valid_r;
    logic                    busy_r;
    logic                    done_r;
    logic [7:0]              overrun_r;

    logic signed [W-1:0]     tgt_sel_s;
    logic signed [W-1:0]     proc_sel_s;
    logic signed [IW-1:0]    int_sel_s;
    logic signed [EW-1:0]    err_s;
    logic signed [IW-1:0]    int_sum_s;
    logic signed [IW-1:0]    int_new_s;
    logic signed [SW-1:0]    sum_s;
    logic signed [W-1:0]     drive_sat_s;
    logic                    last_ch_s;

`ifdef PID_INT_CLAMP_EN
    localparam logic signed [IW-1:0] INT_HI = IW'(INT_LIM);
    localparam logic signed [IW-1:0] INT_LO = -INT_HI;
`endif

    // Datapath for the active channel: error, integrator update, and the saturated sum.
    always_comb begin
        tgt_sel_s  = shadow_tgt_r[ch_r*W +: W];
        proc_sel_s = shadow_proc_r[ch_r*W +: W];
        int_sel_s  = int_r[ch_r];
        err_s      = EW'(tgt_sel_s) - EW'(proc_sel_s);
        int_sum_s  = int_sel_s + IW'(err_s);
`ifdef PID_INT_CLAMP_EN
        if (int_sum_s > INT_HI) begin
            int_new_s = INT_HI;
        end else if (int_sum_s < INT_LO) begin
            int_new_s = INT_LO;
        end else begin
            int_new_s = int_sum_s;
        end
`else
        int_new_s = int_sum_s;
`endif
        sum_s = SW'(proc_sel_s) + SW'(prod_p_r >>> SHIFT) + SW'(prod_i_r >>> SHIFT);
        if (sum_s > OUT_HI) begin
            drive_sat_s = W'(OUT_HI);
        end else if (sum_s < OUT_LO) begin
            drive_sat_s = W'(OUT_LO);
        end else begin
            drive_sat_s = W'(sum_s);
        end
        last_ch_s = (ch_r == CW'(NCH - 1));
    end

    // Sequencer FSM: snapshot, per-channel pipeline, registered status and drive outputs.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_r       <= ST_IDLE;
            ch_r          <= '0;
            shadow_tgt_r  <= '0;
            shadow_proc_r <= '0;
            err_r         <= '0;
            int_new_r     <= '0;
            prod_p_r      <= '0;
            prod_i_r      <= '0;
            drive_r       <= '0;
            drive_valid_r <= '0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            overrun_r     <= 8'd0;
        end else begin
            drive_valid_r <= '0;
            done_r        <= 1'b0;
            if (tick && (state_r != ST_IDLE) && (overrun_r != 8'd255)) begin
                overrun_r <= overrun_r + 8'd1;
            end
            case (state_r)
                ST_IDLE: begin
                    if (tick) begin
                        shadow_tgt_r  <= target_flat;
                        shadow_proc_r <= process_flat;
                        ch_r          <= '0;
                        busy_r        <= 1'b1;
                        state_r       <= ST_ERR;
                    end
                end
                ST_ERR: begin
                    err_r     <= err_s;
                    int_new_r <= int_new_s;
                    state_r   <= ST_MULP;
                end
                ST_MULP: begin
                    prod_p_r <= PPW'($signed(kp)) * PPW'(err_r);
                    state_r  <= ST_MULI;
                end
                ST_MULI: begin
                    prod_i_r <= PIW'($signed(ki)) * PIW'(int_new_r);
                    state_r  <= ST_SUM;
                end
                ST_SUM: begin
                    drive_r[ch_r*W +: W] <= drive_sat_s;
                    drive_valid_r[ch_r]  <= 1'b1;
                    if (last_ch_s) begin
                        ch_r    <= '0;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= ST_IDLE;
                    end else begin
                        ch_r    <= ch_r + CW'(1);
                        state_r <= ST_ERR;
                    end
                end
                default: begin
                    ch_r    <= '0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Per-channel integrator storage. A clear takes priority over the SUM write-back.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            for (int k = 0; k < NCH; k++) begin
                int_r[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (clear_int[k]) begin
                    int_r[k] <= '0;
                end else if ((state_r == ST_SUM) && (ch_r == CW'(k))) begin
                    int_r[k] <= int_new_r;
                end else begin
                    int_r[k] <= int_r[k];
                end
            end
        end
    end

    assign drive_flat  = drive_r;
    assign drive_valid = drive_valid_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign overrun_cnt = overrun_r;

endmodule

// File: tb/tb_pid_channel_scheduler.sv
// tb_pid_channel_scheduler
// Directed test bench for pid_channel_scheduler with NCH=4, W=32, SHIFT=3,
// OUT_LIM=20000 and INT_LIM=50. Every expected value is worked out by hand
// from the PI equation. When PID_INT_CLAMP_EN is defined, the integral test
// expects the anti-windup results.
module tb_pid_channel_scheduler;

    localparam int NCH = 4;
    localparam int W   = 32;

    logic               clk;
    logic               nRst;
    logic               tick;
    logic [NCH*W-1:0]   target_flat;
    logic [NCH*W-1:0]   process_flat;
    logic [W-1:0]       kp;
    logic [W-1:0]       ki;
    logic [NCH-1:0]     clear_int;
    logic [NCH*W-1:0]   drive_flat;
    logic [NCH-1:0]     drive_valid;
    logic               busy;
    logic               done;
    logic [7:0]         overrun_cnt;

    int compare_cnt;
    int mismatch_cnt;

    pid_channel_scheduler #(
        .NCH(NCH), .W(W), .SHIFT(3), .OUT_LIM(20000), .INT_LIM(50)
    ) dut (
        .clk(clk), .nRst(nRst), .tick(tick),
        .target_flat(target_flat), .process_flat(process_flat),
        .kp(kp), .ki(ki), .clear_int(clear_int),
        .drive_flat(drive_flat), .drive_valid(drive_valid),
        .busy(busy), .done(done), .overrun_cnt(overrun_cnt)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic signed [63:0] got,
                             input logic signed [63:0] exp);
        compare_cnt++;
        if (got !== exp) begin
            mismatch_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic signed [W-1:0] drv(input int k);
        return drive_flat[k*W +: W];
    endfunction

    task automatic set_ch(input int k, input int tgt, input int prc);
        target_flat[k*W +: W]  = tgt;
        process_flat[k*W +: W] = prc;
    endtask

    task automatic clear_chans();
        for (int k = 0; k < NCH; k++) set_ch(k, 0, 0);
    endtask

    // Raise tick for one edge (E0). Returns 1 ns after E0.
    task automatic tick_once();
        @(negedge clk);
        tick = 1'b1;
        @(posedge clk);
        #1;
        tick = 1'b0;
    endtask

    // Advance n rising edges, then settle 1 ns past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One full control cycle. Returns 1 ns after E16, which is the done cycle.
    task automatic run_cycle();
        tick_once();
        step(16);
    endtask

    task automatic do_reset();
        @(negedge clk);
        nRst = 1'b0;
        @(negedge clk);
        nRst = 1'b1;
    endtask

    initial begin
        int exp_int[4];
        compare_cnt  = 0;
        mismatch_cnt = 0;
        nRst = 1'b0; tick = 1'b0; kp = '0; ki = '0; clear_int = '0;
        target_flat = '0; process_flat = '0;

        // Reset state
        step(2);
        for (int k = 0; k < NCH; k++) check_val("reset_drive", drv(k), 0);
        check_val("reset_valid", drive_valid, 0);
        check_val("reset_busy", busy, 0);
        check_val("reset_done", done, 0);
        check_val("reset_ovr", overrun_cnt, 0);
        @(negedge clk);
        nRst = 1'b1;

        // Latency and proportional path: 40 + (8*60 >>> 3) = 100
        kp = 32'sd8; ki = 32'sd0; clear_chans(); set_ch(0, 100, 40);
        tick_once();
        step(3);
        check_val("p_valid_E3", drive_valid, 0);
        step(1);
        check_val("p_valid_E4", drive_valid, 4'b0001);
        check_val("p_drive0", drv(0), 100);
        check_val("p_busy_E4", busy, 1);
        step(11);
        check_val("p_busy_E15", busy, 1);
        check_val("p_done_E15", done, 0);
        step(1);
        check_val("p_done_E16", done, 1);
        check_val("p_busy_E16", busy, 0);
        check_val("p_valid_E16", drive_valid, 4'b1000);
        step(1);
        check_val("p_done_E17", done, 0);
        check_val("p_hold0", drv(0), 100);

        // Integral accumulation and clear
        do_reset();
        kp = 32'sd0; ki = 32'sd8; clear_chans(); set_ch(0, 10, 0);
        for (int i = 1; i <= 3; i++) begin
            run_cycle();
            check_val("i_accum", drv(0), 10 * i);
        end
        @(negedge clk);
        clear_int = 4'b0001;
        @(posedge clk);
        #1;
        clear_int = '0;
        run_cycle();
        check_val("i_after_clear", drv(0), 10);
        // Clear during the ch0 SUM: drive uses int_new=20, but storage is cleared
        tick_once();
        step(3);
        clear_int = 4'b0001;
        step(1);
        clear_int = '0;
        check_val("i_clr_sum_drive", drv(0), 20);
        step(12);
        run_cycle();
        check_val("i_clr_sum_next", drv(0), 10);

        // Saturation and floor shift
        do_reset();
        kp = 32'sd8000; ki = 32'sd0; clear_chans();
        set_ch(0, 100, 0); set_ch(1, 0, 100);
        run_cycle();
        check_val("sat_pos", drv(0), 20000);
        check_val("sat_neg", drv(1), -20000);
        kp = 32'sd1; set_ch(0, -1, 0);
        run_cycle();
        check_val("floor_m1", drv(0), -1);
        check_val("floor_m100", drv(1), 87);

        // Overrun counting
        do_reset();
        kp = 32'sd0; ki = 32'sd0; clear_chans();
        tick_once();
        step(4);
        tick_once();
        check_val("ovr_one", overrun_cnt, 1);
        step(11);
        check_val("ovr_done_E16", done, 1);
        @(negedge clk);
        tick = 1'b1;
        repeat (300) @(posedge clk);
        #1;
        tick = 1'b0;
        step(20);
        check_val("ovr_sat", overrun_cnt, 255);
        check_val("ovr_idle_busy", busy, 0);

        // Snapshot isolation, then reset mid-sequence
        do_reset();
        kp = 32'sd8; ki = 32'sd0;
        for (int k = 0; k < NCH; k++) set_ch(k, 100 * (k + 1), 0);
        tick_once();
        step(5);
        target_flat = '0;
        step(11);
        check_val("snap_d0", drv(0), 100);
        check_val("snap_d2", drv(2), 300);
        check_val("snap_d3", drv(3), 400);
        tick_once();
        step(8);
        @(negedge clk);
        nRst = 1'b0;
        #1;
        for (int k = 0; k < NCH; k++) check_val("rst_mid_drive", drv(k), 0);
        check_val("rst_mid_valid", drive_valid, 0);
        check_val("rst_mid_busy", busy, 0);
        check_val("rst_mid_done", done, 0);
        @(negedge clk);
        nRst = 1'b1;
        kp = 32'sd0; ki = 32'sd8;
        for (int k = 0; k < NCH; k++) set_ch(k, 10, 0);
        run_cycle();
        check_val("rst_next_done", done, 1);
        for (int k = 0; k < NCH; k++) check_val("rst_int_zero", drv(k), 10);

        // Integrator wrap versus anti-windup clamp (INT_LIM=50)
`ifdef PID_INT_CLAMP_EN
        exp_int = '{30, 50, 50, 50};
`else
        exp_int = '{30, 60, 90, 120};
`endif
        do_reset();
        kp = 32'sd0; ki = 32'sd8; clear_chans(); set_ch(0, 30, 0);
        for (int i = 0; i < 4; i++) begin
            run_cycle();
            check_val("int_clamp", drv(0), exp_int[i]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_cnt, mismatch_cnt);
        $finish;
    end

endmodule
